regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-read-port register file, the next generation of the core's 32x32 integer register file. Configurable data width, depth and read-port count, with optional hardwired-zero entry 0. Contains a post-reset clear sequencer that zeroes every entry, so the storage array needs no reset and still starts deterministic. Sits between decode (read addresses) and writeback (write port) in the pipeline.

Parameters:
DATA_W, 32, width of each entry in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent combinational read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  input  1  clock, all state updates on rising edge
srst_n  input  1  asynchronous active-low reset
wen  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
raddr  input  NUM_RD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rdata  output  NUM_RD*DATA_W  read data; port k = bits [k*DATA_W +: DATA_W]
busy  output  1  high while the clear sequence runs; writes are ignored while high
clr_done  output  1  single-cycle pulse on the cycle the clear sequence finishes

Behaviour:
- Clock is clk; reset is srst_n, asynchronous and active-low. Reset acts only on the control state (FSM, clear counter, busy, clr_done). The storage array has no reset.
- Reset values: state = CLEAR, clr_cnt = 0, busy = 1, clr_done = 0. While busy = 1, rdata is forced to 0 on all ports.
- FSM states and transitions:
  - CLEAR: each cycle, write 0 into entry clr_cnt, then increment clr_cnt.
  - CLEAR -> READY: on the edge that writes entry DEPTH-1. busy falls and clr_done pulses high for exactly 1 cycle on the following cycle.
  - READY: stays in READY until reset.
- Clear duration: exactly DEPTH cycles after srst_n deasserts (32 cycles at default parameters).
- Reset mid-clear, or reset in READY: asynchronous return to CLEAR with clr_cnt = 0, and the full sweep restarts. Array contents left over from before the reset are not relied on.
- Write (READY only): if wen = 1, then mem[waddr] <= wdata at the rising edge. Write-to-read latency is 1 cycle.
- Writes while busy = 1 are dropped silently, with no error indication. The upstream pipeline holds until busy = 0.
- Reads are combinational: rdata[k] = mem[raddr[k]], with 0 cycles of latency. All ports are independent, and any number of ports may read the same address.
- With ZERO_REG = 1:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0 regardless of array contents or bypass.
- With ZERO_REG = 0: entry 0 behaves like any other entry and is cleared by the sweep.
- Simultaneous write and read of the same address in the same cycle: the result depends on REGFILE_BYPASS_EN (see Optional Feature).
- Width rules: addresses are used unmodified. Every DEPTH address is valid, so there is no out-of-range case.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through bypass.
  - If wen = 1, busy = 0 and raddr[k] == waddr (and, when ZERO_REG = 1, waddr != 0), then rdata[k] = wdata in the same cycle.
  - This removes the WB->ID hazard.
- Undefined: rdata[k] returns the pre-write array value; the new value is visible from the next cycle. The pipeline must then forward externally.

Test Plan:
1. Reset, then release srst_n → busy = 1 for exactly 32 cycles, clr_done pulses once at cycle 32, and all 32 entries read 0x00000000 afterwards.
2. In READY: write 0xDEADBEEF to x5, then read port 0 = 5 and port 1 = 5 on the next cycle → both ports return 0xDEADBEEF.
3. ZERO_REG = 1: write 0x12345678 to x0 → reads of x0 on all ports return 0 in the same cycle and in all later cycles.
4. Same-cycle write 0xA5A5A5A5 to x7 with read port 1 = 7 → with REGFILE_BYPASS_EN, rdata1 = 0xA5A5A5A5 that cycle; without it, rdata1 = previous x7 value, then 0xA5A5A5A5 next cycle.
5. Assert srst_n low at clear cycle 10 → busy stays 1, and after release the sweep restarts and takes a full 32 cycles. Additionally, wen = 1 to x3 with 0xFFFFFFFF during busy → x3 reads 0 after clear.
6. NUM_RD = 4, DATA_W = 64, ADDR_W = 4 → clear takes 16 cycles; write distinct 64-bit values to x1..x4, read all four ports at once → each port returns its own entry.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Write/read bus of regfile_mp: one write port, NUM_RD packed read ports and clear status.
// Parameters must match the register file instance that the bus is connected to.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     wen;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     busy;
  logic                     clr_done;

  modport master (
    output wen, waddr, wdata, raddr,
    input  rdata, busy, clr_done
  );

  modport slave (
    input  wen, waddr, wdata, raddr,
    output rdata, busy, clr_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file. After reset it sweeps zeros through every entry.
// Defining REGFILE_BYPASS_EN makes a same-cycle write visible on matching read ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         srst_n,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDR_W-1:0]        clr_cnt;
  logic [ADDR_W-1:0]        clr_cnt_nxt;
  logic                     clr_done_q;
  logic                     clr_done_nxt;
  logic                     busy;
  logic                     wr_ok;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_val;
  logic [NUM_RD*DATA_W-1:0] rdata_all;

  // Storage deliberately has no reset; the clear sweep makes it deterministic.
  logic [DATA_W-1:0] mem [DEPTH];

  assign busy  = (state == CLEAR);
  assign wr_ok = bus.wen && !((ZERO_REG != 0) && (bus.waddr == '0));

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      clr_done_q <= clr_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_cnt_nxt  = clr_cnt;
    clr_done_nxt = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = bus.waddr;
    mem_wdata    = bus.wdata;
    case (state)
      CLEAR: begin
        mem_we      = 1'b1;
        mem_addr    = clr_cnt;
        mem_wdata   = '0;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == {ADDR_W{1'b1}}) begin
          state_nxt    = READY;
          clr_done_nxt = 1'b1;
        end
      end
      READY: begin
        mem_we = wr_ok;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // User writes arriving while busy are simply dropped.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_comb begin
    rdata_all = '0;
    rd_addr   = '0;
    rd_val    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr = bus.raddr[k*ADDR_W +: ADDR_W];
      rd_val  = mem[rd_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (rd_addr == bus.waddr)) begin
        rd_val = bus.wdata;
      end
`endif
      // Hardwired zero and the busy blanking take priority over any bypass.
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
        rd_val = '0;
      end
      if (busy) begin
        rd_val = '0;
      end
      rdata_all[k*DATA_W +: DATA_W] = rd_val;
    end
  end

  assign bus.rdata    = rdata_all;
  assign bus.busy     = busy;
  assign bus.clr_done = clr_done_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp (default build and a 4-port/64-bit/16-entry build).
// Expected read data comes from a plain array model, honouring REGFILE_BYPASS_EN when defined.
module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic srst_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model_mem [DEPTH];
  logic [63:0] val2 [5];

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();
  regfile_mp_if #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4)) bus2 ();

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut (
    .clk(clk), .srst_n(srst_n), .bus(bus)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) dut2 (
    .clk(clk), .srst_n(srst_n), .bus(bus2)
  );

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wen && bus.waddr == ra) return bus.wdata;
`endif
    return model_mem[ra];
  endfunction

  // Called just after a rising edge in READY; checks reads, then commits the write at the next edge.
  task automatic apply_stimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] r0, input logic [4:0] r1, input string tag);
    bus.wen   = w;
    bus.waddr = wa;
    bus.wdata = wd;
    bus.raddr = {r1, r0};
    #2;
    check_output({tag, "_p0"}, bus.rdata[31:0], model_read(r0));
    check_output({tag, "_p1"}, bus.rdata[63:32], model_read(r1));
    @(posedge clk);
    if (w && wa != 5'd0) model_mem[wa] = wd;
    #1;
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    int n2 = 0;
    bit done = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n2 == 0 && !bus2.busy) begin
        n2 = n;
        check_output({tag, "_done16"}, bus2.clr_done, 1);
      end
      if (!bus.busy) begin
        done = 1;
        bus.wen = 1'b0;
      end
    end
    check_output({tag, "_len"}, n, DEPTH);
    check_output({tag, "_len16"}, n2, 16);
    check_output({tag, "_done"}, bus.clr_done, 1);
    @(posedge clk);
    #1;
    check_output({tag, "_pulse"}, bus.clr_done, 0);
    check_output({tag, "_busy"}, bus.busy, 0);
    foreach (model_mem[i]) model_mem[i] = 32'd0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] wa;
    bus.wen = 0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
    bus2.wen = 0; bus2.waddr = '0; bus2.wdata = '0; bus2.raddr = '0;

    #2 srst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy", bus.busy, 1);
    check_output("rst_done", bus.clr_done, 0);
    check_output("rst_rdata", bus.rdata, 0);
    srst_n = 1'b1;
    wait_clear("clr1");
    for (int i = 0; i < DEPTH; i++)
      apply_stimulus(0, 5'd0, 32'd0, 5'(i), 5'(DEPTH - 1 - i), "clr_read");

    apply_stimulus(1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, "w5");
    apply_stimulus(0, 5'd0, 32'd0, 5'd5, 5'd5, "r5");

    apply_stimulus(1, 5'd0, 32'h12345678, 5'd0, 5'd0, "x0_same");
    apply_stimulus(0, 5'd0, 32'd0, 5'd0, 5'd0, "x0_later");

    apply_stimulus(1, 5'd7, 32'h11111111, 5'd3, 5'd4, "w7_pre");
    apply_stimulus(1, 5'd7, 32'hA5A5A5A5, 5'd6, 5'd7, "w7_byp");
    apply_stimulus(0, 5'd0, 32'd0, 5'd7, 5'd7, "r7_next");

    repeat (300) begin
      wa = 5'($urandom);
      apply_stimulus(1'($urandom), wa, $urandom, 5'($urandom),
                     ($urandom_range(0, 2) == 0) ? wa : 5'($urandom), "rnd");
    end

    apply_stimulus(1, 5'd3, 32'h12121212, 5'd0, 5'd0, "w3");
    bus.raddr = {5'd3, 5'd5};
    srst_n = 1'b0;
    #2;
    check_output("ready_rst_busy", bus.busy, 1);
    check_output("ready_rst_rdata", bus.rdata, 0);
    @(posedge clk);
    #1 srst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 srst_n = 1'b0;
    #1;
    check_output("mid_rst_busy", bus.busy, 1);
    @(posedge clk);
    #1;
    bus.wen = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hFFFFFFFF;
    srst_n = 1'b1;
    wait_clear("clr2");
    apply_stimulus(0, 5'd0, 32'd0, 5'd3, 5'd5, "x3_after");

    for (int i = 1; i <= 4; i++) begin
      val2[i] = {32'hC0DE0000 | 32'(i), $urandom};
      bus2.wen = 1'b1; bus2.waddr = 4'(i); bus2.wdata = val2[i];
      @(posedge clk);
      #1;
    end
    bus2.wen = 1'b0;
    bus2.raddr = {4'd4, 4'd3, 4'd2, 4'd1};
    #2;
    for (int k = 0; k < 4; k++) check_output("wide_fwd", bus2.rdata[k*64 +: 64], val2[k+1]);
    bus2.raddr = {4'd1, 4'd2, 4'd3, 4'd4};
    #2;
    for (int k = 0; k < 4; k++) check_output("wide_rev", bus2.rdata[k*64 +: 64], val2[4-k]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
